// File: rtl/mac_window_16_if.sv
// Handshake and data bus between mac_window_16 and its buffers and consumer.
// The master side is the environment; the slave side is the MAC engine.
interface mac_window_16_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
);
  logic              start;
  logic              rd_en;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] weight_in;
  logic              busy;
  logic              res_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic [DATA_W-1:0] q_out;

  modport master (
    output start, data_in, weight_in, out_ready,
    input  rd_en, busy, res_valid, acc_out, q_out
  );

  modport slave (
    input  start, data_in, weight_in, out_ready,
    output rd_en, busy, res_valid, acc_out, q_out
  );
endinterface

// File: rtl/mac_window_16.sv
// 16-element signed multiply-accumulate over a window/weight buffer pair,
// with a shift/ReLU/clip quantiser and a valid/ready result handshake.
module mac_window_16 #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int SHIFT  = 0,
  parameter int RELU   = 0
) (
  input  logic           clk,
  input  logic           rst,
  mac_window_16_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic signed [ACC_W-1:0] Q_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Q_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t                       r_state;
  state_t                       w_state_next;
  logic                         w_clear;
  logic [3:0]                   r_cnt;
  logic                         r_valid;
  logic signed [ACC_W-1:0]      r_acc;
  logic signed [ACC_W-1:0]      r_acc_out;
  logic [DATA_W-1:0]            r_q_out;
  logic signed [2*DATA_W-1:0]   w_data_ext;
  logic signed [2*DATA_W-1:0]   w_weight_ext;
  logic signed [2*DATA_W-1:0]   w_prod;
  logic signed [ACC_W-1:0]      w_prod_ext;
  logic signed [ACC_W-1:0]      w_acc_sum;

  // Shift, optional rectify, then clip into the signed DATA_W range.
  function automatic logic [DATA_W-1:0] f_quant(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] t;
    t = a >>> SHIFT;
    if ((RELU != 0) && t[ACC_W-1]) f_quant = {DATA_W{1'b0}};
    else if (t > Q_MAX)            f_quant = Q_MAX[DATA_W-1:0];
    else if (t < Q_MIN)            f_quant = Q_MIN[DATA_W-1:0];
    else                           f_quant = t[DATA_W-1:0];
  endfunction

  // Next-state decode; the start edge also clears accumulator and counter.
  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = S_READ;
          w_clear      = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_READ: begin
        if (r_cnt == 4'd15) w_state_next = S_DRAIN;
        else                w_state_next = S_READ;
      end
      S_DRAIN: w_state_next = S_DONE;
      S_DONE: begin
        if (bus.out_ready) w_state_next = S_IDLE;
        else               w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Full-precision product, sign-extended into the accumulator width.
  always_comb begin
    w_data_ext   = {{DATA_W{bus.data_in[DATA_W-1]}}, bus.data_in};
    w_weight_ext = {{DATA_W{bus.weight_in[DATA_W-1]}}, bus.weight_in};
    w_prod       = w_data_ext * w_weight_ext;
    w_prod_ext   = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    if (r_valid) w_acc_sum = r_acc + w_prod_ext;
    else         w_acc_sum = r_acc;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Datapath: data arrives one cycle after each read strobe, and the
  // result registers load on the DRAIN edge so they hold across IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= 4'd0;
      r_valid   <= 1'b0;
      r_acc     <= {ACC_W{1'b0}};
      r_acc_out <= {ACC_W{1'b0}};
      r_q_out   <= {DATA_W{1'b0}};
    end else begin
      r_valid <= (r_state == S_READ);
      if (w_clear) begin
        r_acc <= {ACC_W{1'b0}};
        r_cnt <= 4'd0;
      end else begin
        r_acc <= w_acc_sum;
        if (r_state == S_READ) r_cnt <= r_cnt + 4'd1;
        else                   r_cnt <= r_cnt;
      end
      if (r_state == S_DRAIN) begin
        r_acc_out <= w_acc_sum;
        r_q_out   <= f_quant(w_acc_sum);
      end else begin
        r_acc_out <= r_acc_out;
        r_q_out   <= r_q_out;
      end
    end
  end

  assign bus.rd_en     = (r_state == S_READ);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.res_valid = (r_state == S_DONE);
  assign bus.acc_out   = r_acc_out;
  assign bus.q_out     = r_q_out;

endmodule

// File: tb/tb_mac_window_16.sv
// Self-checking bench for mac_window_16: three parameter variants run in
// lockstep against a sum-of-products and quantiser model.
module tb_mac_window_16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_window_16_if #(.DATA_W(8), .ACC_W(20)) b0 ();
  mac_window_16_if #(.DATA_W(8), .ACC_W(20)) b1 ();
  mac_window_16_if #(.DATA_W(8), .ACC_W(20)) b2 ();

  mac_window_16 #(.DATA_W(8), .ACC_W(20), .SHIFT(0),  .RELU(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  mac_window_16 #(.DATA_W(8), .ACC_W(20), .SHIFT(12), .RELU(0)) u1 (.clk(clk), .rst(rst), .bus(b1));
  mac_window_16 #(.DATA_W(8), .ACC_W(20), .SHIFT(0),  .RELU(1)) u2 (.clk(clk), .rst(rst), .bus(b2));

  int errors = 0;
  int checks = 0;
  int d_arr[16];
  int w_arr[16];
  int acc_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int q_model(input int acc, input int sh, input int relu);
    int t;
    t = acc >>> sh;
    if (relu != 0 && t < 0) t = 0;
    if (t > 127) t = 127;
    if (t < -128) t = -128;
    return t;
  endfunction

  task automatic set_start(input logic v);
    b0.start = v; b1.start = v; b2.start = v;
  endtask

  task automatic set_ready(input logic v);
    b0.out_ready = v; b1.out_ready = v; b2.out_ready = v;
  endtask

  task automatic set_data(input int d, input int w);
    logic [7:0] d8, w8;
    d8 = d[7:0];
    w8 = w[7:0];
    b0.data_in = d8; b1.data_in = d8; b2.data_in = d8;
    b0.weight_in = w8; b1.weight_in = w8; b2.weight_in = w8;
  endtask

  task automatic fill_const(input int d, input int w);
    for (int i = 0; i < 16; i++) begin
      d_arr[i] = d;
      w_arr[i] = w;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) begin
      d_arr[i] = int'($urandom_range(255)) - 128;
      w_arr[i] = int'($urandom_range(255)) - 128;
    end
  endtask

  task automatic check_outputs(input string tag, input int acc);
    logic [19:0] a20;
    int q0, q1, q2;
    a20 = acc[19:0];
    q0 = q_model(acc, 0, 0);
    q1 = q_model(acc, 12, 0);
    q2 = q_model(acc, 0, 1);
    check({tag, "_acc0"}, 32'(b0.acc_out), 32'(a20));
    check({tag, "_acc1"}, 32'(b1.acc_out), 32'(a20));
    check({tag, "_acc2"}, 32'(b2.acc_out), 32'(a20));
    check({tag, "_q0"}, 32'(b0.q_out), 32'(q0[7:0]));
    check({tag, "_q1"}, 32'(b1.q_out), 32'(q1[7:0]));
    check({tag, "_q2"}, 32'(b2.q_out), 32'(q2[7:0]));
  endtask

  // Starts a window, plays the upstream buffer (data one cycle after each
  // rd_en), and checks strobe count and result latency. abort_at > 0 pulses
  // reset during that rd_en cycle instead.
  task automatic run_window(input string tag, input int abort_at, output int acc);
    int rdn, first_rd, last_rd, idx, vld_at;
    logic rd;
    acc = 0;
    for (int i = 0; i < 16; i++) acc += d_arr[i] * w_arr[i];
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    rdn = 0; idx = 0; first_rd = -1; last_rd = -1; vld_at = -1;
    for (int c = 0; c < 40 && vld_at < 0; c++) begin
      @(negedge clk);
      rd = b0.rd_en;
      if (b0.res_valid) vld_at = c;
      if (rd) begin
        rdn++;
        if (first_rd < 0) first_rd = c;
        last_rd = c;
      end
      if (abort_at > 0 && rd && rdn == abort_at) begin
        rst = 1'b1;
        #1;
        check({tag, "_abort_rd"}, 32'(b0.rd_en), 32'(1'b0));
        check({tag, "_abort_busy"}, 32'(b0.busy), 32'(1'b0));
        check({tag, "_abort_busy2"}, 32'(b2.busy), 32'(1'b0));
        check({tag, "_abort_vld"}, 32'(b0.res_valid), 32'(1'b0));
        check({tag, "_abort_acc"}, 32'(b0.acc_out), 32'(0));
        check({tag, "_abort_q"}, 32'(b0.q_out), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (vld_at < 0) begin
        @(posedge clk); #1;
        if (rd && idx < 16) begin
          set_data(d_arr[idx], w_arr[idx]);
          idx++;
        end else begin
          set_data(int'($urandom_range(255)), int'($urandom_range(255)));
        end
      end
    end
    check({tag, "_rd_count"}, 32'(rdn), 32'(16));
    check({tag, "_rd_first"}, 32'(first_rd), 32'(0));
    check({tag, "_rd_last"}, 32'(last_rd), 32'(15));
    check({tag, "_vld_at"}, 32'(vld_at), 32'(17));
    check({tag, "_vld1"}, 32'(b1.res_valid), 32'(1'b1));
    check({tag, "_vld2"}, 32'(b2.res_valid), 32'(1'b1));
    check({tag, "_busy"}, 32'(b0.busy), 32'(1'b1));
    check_outputs(tag, acc);
  endtask

  // Holds out_ready low for 'hold' DONE cycles (optionally poking start),
  // then handshakes with start also high; ends in the first IDLE cycle.
  task automatic finish_window(input string tag, input int hold, input bit poke, input int acc);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      set_start(poke && (i % 2 == 1));
      @(negedge clk);
      check({tag, "_hold_vld"}, 32'(b0.res_valid), 32'(1'b1));
      check({tag, "_hold_rd"}, 32'(b0.rd_en), 32'(1'b0));
      check_outputs({tag, "_hold"}, acc);
    end
    set_ready(1'b1);
    set_start(1'b1);
    @(posedge clk); #1;
    set_ready(1'b0);
    set_start(1'b0);
    @(negedge clk);
    check({tag, "_idle_vld"}, 32'(b0.res_valid), 32'(1'b0));
    check({tag, "_idle_busy"}, 32'(b0.busy), 32'(1'b0));
    check({tag, "_idle_rd"}, 32'(b0.rd_en), 32'(1'b0));
    check_outputs({tag, "_idle"}, acc);
  endtask

  initial begin
    rst = 1'b1;
    set_start(1'b0);
    set_ready(1'b0);
    set_data(0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd", 32'(b0.rd_en), 32'(1'b0));
    check("rst_busy", 32'(b0.busy), 32'(1'b0));
    check("rst_vld", 32'(b0.res_valid), 32'(1'b0));
    check_outputs("rst", 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("wait_idle_busy", 32'(b0.busy), 32'(1'b0));

    fill_const(1, 1);
    run_window("unit", 0, acc_e);
    check("unit_acc_const", 32'(acc_e), 32'(16));
    finish_window("unit", 0, 1'b0, acc_e);

    fill_const(-128, -128);
    run_window("sat", 0, acc_e);
    check("sat_q1_shift12", 32'(b1.q_out), 32'(8'd64));
    finish_window("sat", 5, 1'b1, acc_e);

    fill_const(1, -1);
    run_window("relu", 0, acc_e);
    check("relu_q2_zero", 32'(b2.q_out), 32'(8'd0));
    finish_window("relu", 0, 1'b0, acc_e);

    for (int n = 0; n < 5; n++) begin
      fill_rand();
      if (n == 2) d_arr[5] = -128;
      run_window("rand", 0, acc_e);
      finish_window("rand", int'($urandom_range(3)), 1'b1, acc_e);
    end

    fill_rand();
    run_window("abort", 8, acc_e);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("post_abort_busy", 32'(b0.busy), 32'(1'b0));
    fill_const(2, 3);
    run_window("after_abort", 0, acc_e);
    check("after_abort_acc96", 32'(b0.acc_out), 32'(20'd96));
    finish_window("after_abort", 0, 1'b0, acc_e);

    fill_rand();
    run_window("final", 0, acc_e);
    finish_window("final", 2, 1'b0, acc_e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
